// File: rtl/apu_frame_pkg.sv
// APU frame sequencer shared definitions.
// Step positions are in CPU cycles since the last counter reset.
package apu_frame_pkg;

    localparam int STEP_Q1    = 7457;
    localparam int STEP_H1    = 14913;
    localparam int STEP_Q3    = 22371;
    localparam int STEP_IRQ0  = 29828;
    localparam int STEP_H2_4  = 29829;
    localparam int STEP_END_4 = 29830;
    localparam int STEP_H2_5  = 37281;
    localparam int STEP_END_5 = 37282;

    typedef enum logic {
        MODE_4STEP,
        MODE_5STEP
    } frame_mode_t;

endpackage

// File: rtl/apu_frame_wr_delay.sv
// $4017 write-to-counter-reset delay.
// Tracks one pending reset; a newer write restarts the countdown.
module apu_frame_wr_delay #(
    parameter int DLY_EVEN = 4,
    parameter int DLY_ODD  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_en,
    input  logic wr,
    input  logic phase,
    output logic cnt_clear
);

    localparam int DMAX = (DLY_EVEN > DLY_ODD) ? DLY_EVEN : DLY_ODD;
    localparam int DW   = $clog2(DMAX + 1);

    logic          pending;
    logic [DW-1:0] dly;

    assign cnt_clear = pending && cpu_en && !wr && (dly == DW'(1));

    // Reload on each write, count CPU cycles down while pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            dly     <= '0;
        end else if (wr) begin
            pending <= 1'b1;
            dly     <= phase ? DW'(DLY_ODD) : DW'(DLY_EVEN);
        end else if (cpu_en && pending) begin
            dly <= dly - DW'(1);
            if (dly == DW'(1)) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame strobes and frame IRQ.
// Step decode uses the counter value before the CPU-cycle increment.
module apu_frame_counter
    import apu_frame_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DLY_EVEN = 4,
    parameter int DLY_ODD  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       wr_4017,
    input  logic [7:0] wdata,
    input  logic       rd_4015,
    output logic       apuclk,
    output logic       qframe,
    output logic       hframe,
    output logic       irq
);

    logic [CNT_W-1:0] cnt;
    logic             phase;
    frame_mode_t      mode;
    logic             inhibit;
    logic             cnt_clear;
    logic             dec_q;
    logic             dec_h;
    logic             dec_irq;
    logic             at_end;
    logic             inh_now;
    logic             irq_set;
    logic             clr_qh;
    logic             unused_bits;

    assign unused_bits = ^wdata[5:0];

    apu_frame_wr_delay #(
        .DLY_EVEN(DLY_EVEN),
        .DLY_ODD (DLY_ODD)
    ) u_wr_delay (
        .clk      (clk),
        .reset    (reset),
        .cpu_en   (cpu_en),
        .wr       (wr_4017),
        .phase    (phase),
        .cnt_clear(cnt_clear)
    );

    // Decode the current step for the active sequence mode.
    always_comb begin
        dec_q   = 1'b0;
        dec_h   = 1'b0;
        dec_irq = 1'b0;
        at_end  = 1'b0;
        if (mode == MODE_4STEP) begin
            case (cnt)
                CNT_W'(STEP_Q1),
                CNT_W'(STEP_Q3): dec_q = 1'b1;
                CNT_W'(STEP_H1): begin
                    dec_q = 1'b1;
                    dec_h = 1'b1;
                end
                CNT_W'(STEP_IRQ0): dec_irq = 1'b1;
                CNT_W'(STEP_H2_4): begin
                    dec_q   = 1'b1;
                    dec_h   = 1'b1;
                    dec_irq = 1'b1;
                end
                CNT_W'(STEP_END_4): begin
                    dec_irq = 1'b1;
                    at_end  = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (cnt)
                CNT_W'(STEP_Q1),
                CNT_W'(STEP_Q3): dec_q = 1'b1;
                CNT_W'(STEP_H1),
                CNT_W'(STEP_H2_5): begin
                    dec_q = 1'b1;
                    dec_h = 1'b1;
                end
                CNT_W'(STEP_END_5): at_end = 1'b1;
                default: ;
            endcase
        end
    end

    // A write carrying inhibit overrides an IRQ point in the same cycle.
    assign inh_now = wr_4017 ? wdata[6] : inhibit;
    assign irq_set = cpu_en && dec_irq && !inh_now;
    assign clr_qh  = cnt_clear && (mode == MODE_5STEP);

    // Frame state, registered strobes and the IRQ flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            phase   <= 1'b0;
            mode    <= MODE_4STEP;
            inhibit <= 1'b0;
            apuclk  <= 1'b0;
            qframe  <= 1'b0;
            hframe  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            apuclk <= cpu_en && phase;
            qframe <= cpu_en && (dec_q || clr_qh);
            hframe <= cpu_en && (dec_h || clr_qh);
            if (cpu_en) begin
                phase <= ~phase;
                if (cnt_clear) begin
                    cnt <= '0;
                end else if (at_end) begin
                    cnt <= CNT_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (wr_4017) begin
                mode    <= frame_mode_t'(wdata[7]);
                inhibit <= wdata[6];
            end
            if (wr_4017 && wdata[6]) begin
                irq <= 1'b0;
            end else if (irq_set) begin
                irq <= 1'b1;
            end else if (rd_4015) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: step-rule model plus pinned events.
// Long stretches use randomized cpu_en gaps and $4015 reads.
module tb_apu_frame_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_en = 1'b0;
    logic       wr_4017 = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_4015 = 1'b0;
    logic       apuclk;
    logic       qframe;
    logic       hframe;
    logic       irq;

    apu_frame_counter dut (
        .clk    (clk),
        .reset  (reset),
        .cpu_en (cpu_en),
        .wr_4017(wr_4017),
        .wdata  (wdata),
        .rd_4015(rd_4015),
        .apuclk (apuclk),
        .qframe (qframe),
        .hframe (hframe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit rd_ok = 1'b1;

    // Model: CPU cycles since counter reset, and frame settings.
    int m_cnt = 0;
    int m_phase = 0;
    int m_mode = 0;
    int m_inh = 0;
    int m_irq = 0;
    int m_pend = 0;
    bit e_apu, e_q, e_h, e_irq;

    function automatic bit is_q(int md, int c);
        if (c == 7457 || c == 14913 || c == 22371) return 1;
        return c == (md ? 37281 : 29829);
    endfunction

    function automatic bit is_h(int md, int c);
        return c == 14913 || c == (md ? 37281 : 29829);
    endfunction

    function automatic bit is_irq_pt(int md, int c);
        return md == 0 && c >= 29828 && c <= 29830;
    endfunction

    function automatic int frame_len(int md);
        return md ? 37282 : 29830;
    endfunction

    task automatic model_step();
        bit clr;
        bit setp;
        int inh_eff;
        if (reset) begin
            m_cnt = 0; m_phase = 0; m_mode = 0;
            m_inh = 0; m_irq = 0; m_pend = 0;
            e_apu = 0; e_q = 0; e_h = 0; e_irq = 0;
            return;
        end
        clr = 0;
        e_apu = cpu_en && m_phase == 1;
        e_q = cpu_en && is_q(m_mode, m_cnt);
        e_h = cpu_en && is_h(m_mode, m_cnt);
        if (wr_4017) begin
            m_pend = m_phase ? 3 : 4;
        end else if (cpu_en && m_pend > 0) begin
            m_pend--;
            clr = m_pend == 0;
        end
        if (clr && m_mode == 1) begin
            e_q = 1; e_h = 1;
        end
        inh_eff = wr_4017 ? int'(wdata[6]) : m_inh;
        setp = cpu_en && is_irq_pt(m_mode, m_cnt) && inh_eff == 0;
        if (wr_4017 && wdata[6]) m_irq = 0;
        else if (setp) m_irq = 1;
        else if (rd_4015) m_irq = 0;
        e_irq = m_irq != 0;
        if (cpu_en) begin
            if (clr) m_cnt = 0;
            else if (m_cnt == frame_len(m_mode)) m_cnt = 1;
            else m_cnt++;
            m_phase ^= 1;
        end
        if (wr_4017) begin
            m_mode = int'(wdata[7]);
            m_inh = int'(wdata[6]);
        end
    endtask

    task automatic chk(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b",
                     nm, $time, a, e);
        end
    endtask

    task automatic cyc(input bit en, input bit wr,
                       input logic [7:0] wd, input bit rd,
                       input bit rst);
        cpu_en = en; wr_4017 = wr; wdata = wd;
        rd_4015 = rd; reset = rst;
        model_step();
        @(posedge clk);
        #1;
        chk("apuclk", apuclk, e_apu);
        chk("qframe", qframe, e_q);
        chk("hframe", hframe, e_h);
        chk("irq", irq, e_irq);
        cpu_en = 0; wr_4017 = 0; rd_4015 = 0; reset = 0;
    endtask

    task automatic en1();
        cyc(1, 0, 8'h00, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0, 0);
    endtask

    task automatic wr(input logic [7:0] wd);
        cyc(0, 1, wd, 0, 0);
    endtask

    task automatic goto(input int target);
        int n = 0;
        while (m_cnt != target && n < 60000) begin
            if (target - m_cnt > 8 || target < m_cnt)
                cyc($urandom_range(0, 31) != 0, 0, 8'h00,
                    rd_ok && $urandom_range(0, 63) == 0, 0);
            else begin
                en1();
                idle();
            end
            n++;
        end
        checks++;
        if (m_cnt != target) begin
            failures++;
            $display("FAIL goto actual=%0d required=%0d",
                     m_cnt, target);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("rst_q", qframe, 0);
        chk("rst_h", hframe, 0);
        chk("rst_irq", irq, 0);
        chk("rst_apu", apuclk, 0);
        en1();
        en1();
        chk("apuclk_p1", apuclk, 1);

        // 4-step frame
        goto(7457); en1();
        chk("q_7457", qframe, 1);
        chk("h_7457", hframe, 0);
        goto(14913); en1();
        chk("q_14913", qframe, 1);
        chk("h_14913", hframe, 1);
        goto(22371); en1();
        chk("q_22371", qframe, 1);
        chk("h_22371", hframe, 0);
        rd_ok = 0;
        goto(29828); en1();
        chk("irq_29828", irq, 1);
        chk("q_29828", qframe, 0);
        cyc(0, 0, 8'h00, 1, 0);
        chk("rd_clear", irq, 0);
        cyc(1, 0, 8'h00, 1, 0);
        chk("set_wins", irq, 1);
        chk("q_29829", qframe, 1);
        chk("h_29829", hframe, 1);
        idle();
        chk("irq_hold", irq, 1);
        cyc(1, 1, 8'h40, 0, 0);
        chk("inh_wins", irq, 0);
        for (int k = 0; k < 6; k++) begin
            en1(); idle();
            chk("inh_no_irq", irq, 0);
        end

        // re-write during pending delay
        wr(8'h80); en1(); wr(8'h00);
        for (int k = 0; k < 5; k++) begin
            en1();
            chk("rewr_no_qh", qframe, 0);
        end
        rd_ok = 1;

        // delayed reset from even, then odd phase
        if (m_phase != 0) en1();
        wr(8'h80);
        for (int k = 1; k <= 4; k++) begin
            en1();
            chk("even_q", qframe, k == 4);
            chk("even_h", hframe, k == 4);
        end
        if (m_phase != 1) en1();
        wr(8'h80);
        for (int k = 1; k <= 3; k++) begin
            en1();
            chk("odd_q", qframe, k == 3);
            chk("odd_h", hframe, k == 3);
        end

        // 5-step frame
        goto(14913); en1();
        chk("q5_14913", qframe, 1);
        chk("h5_14913", hframe, 1);
        goto(29828); en1(); en1();
        chk("q5_29829", qframe, 0);
        en1();
        chk("irq5_none", irq, 0);
        goto(37281); en1();
        chk("q5_37281", qframe, 1);
        chk("h5_37281", hframe, 1);
        en1();
        chk("q5_37282", qframe, 0);
        chk("irq5_end", irq, 0);

        // reset with a write pending
        goto(14911);
        wr(8'h80); en1(); en1();
        cyc(1, 0, 8'h00, 0, 1);
        chk("rst_mid_q", qframe, 0);
        chk("rst_mid_h", hframe, 0);
        chk("rst_mid_irq", irq, 0);
        for (int k = 0; k < 8; k++) begin
            en1();
            chk("rst_no_pend", qframe, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/apu_frame_counter.md
Name: apu_frame_counter

Overview:
- Frame sequencer for the APU: generates the quarter-frame (qframe) and half-frame (hframe) strobes that clock the envelope, sweep and length-counter units in every channel, and raises the frame IRQ.
- Programmed through $4017 (mode, IRQ inhibit).
- IRQ flag cleared by a $4015 read; sits beside the channel blocks in the APU top level.

Parameters:
- CNT_W, 16, width of the CPU-cycle step counter.
- DLY_EVEN, 4, CPU cycles from a $4017 write to counter reset when written on an even cycle (phase=0).
- DLY_ODD, 3, CPU cycles from a $4017 write to counter reset when written on an odd cycle (phase=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  one-clk strobe per CPU cycle.
- wr_4017  in  1  one-clk strobe, CPU write to $4017.
- wdata  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit.
- rd_4015  in  1  one-clk strobe, CPU read of $4015.
- apuclk  out  1  one-clk strobe on every second cpu_en (APU cycle).
- qframe  out  1  one-clk quarter-frame strobe.
- hframe  out  1  one-clk half-frame strobe.
- irq  out  1  frame interrupt flag, level; also feeds $4015 bit6.

Behaviour:
- Reset values:
  - All outputs 0.
  - cnt=0, phase=0, mode=0, inhibit=0, no pending write.
- phase:
  - Toggles on each cpu_en.
  - apuclk pulses in the clk cycle after a cpu_en that takes phase 1->0.
- cnt:
  - On cpu_en, cnt increments.
  - All step decodes compare the pre-increment cnt.
  - Strobes are registered and appear in the clk cycle after that cpu_en, one clk wide.
- 4-step mode (mode=0):
  - cnt=7457: q.
  - cnt=14913: q+h.
  - cnt=22371: q.
  - cnt=29828: irq set.
  - cnt=29829: q+h, irq set.
  - cnt=29830: irq set, and cnt wraps to 1 (i.e. 29830 aliases 0).
- 5-step mode (mode=1):
  - cnt=7457: q.
  - cnt=14913: q+h.
  - cnt=22371: q.
  - cnt=29829: nothing.
  - cnt=37281: q+h.
  - cnt=37282: cnt wraps to 1.
  - irq is never set in 5-step mode.
- irq set condition: a 4-step irq point and inhibit=0.
- $4017 write:
  - mode and inhibit update in the same clk cycle.
  - If wdata[6]=1, irq clears that cycle.
  - Delay counter loads DLY_ODD if phase=1, else DLY_EVEN, and decrements on each cpu_en.
  - On the cpu_en where it reaches 0: cnt<=0 and the pending state clears.
  - At that same point, if mode=1, q+h are strobed next clk.
  - Decoded steps continue during the delay.
- Write while a reset is pending: the delay reloads from the current phase. Only the latest write takes effect.
- rd_4015 clears irq.
  - Simultaneous irq set and rd_4015: set wins, irq=1.
  - Simultaneous wr_4017 with inhibit=1 and irq set point: inhibit wins, irq=0.
- reset asserted mid-frame or mid-delay: everything returns to reset values next clk. No strobe is emitted.
- cnt never exceeds 37282; no overflow path exists at CNT_W=16.
- No strobes are generated without cpu_en.

Decomposition:
- Package apu_frame_pkg holds:
  - Step constants: STEP_Q1=7457, STEP_H1=14913, STEP_Q3=22371, STEP_IRQ0=29828, STEP_H2_4=29829, STEP_END_4=29830, STEP_H2_5=37281, STEP_END_5=37282.
  - A typedef enum frame_mode_t {MODE_4STEP, MODE_5STEP}.
- One sub-module is natural: apu_frame_wr_delay, which owns the pending flag and the 3/4-cycle countdown and issues a one-clk cnt_clear.
- Step decode stays in apu_frame_counter.

Test Plan:
- Reset, then cpu_en every 2 clk in 4-step mode, inhibit=0:
  - q at cnt 7457/14913/22371/29829.
  - h at 14913/29829.
  - irq rises after cnt 29828 and stays high; next frame q at 7457 after wrap.
- Clear vs set: with irq=1, pulse rd_4015 -> irq=0 next clk. rd_4015 coincident with cnt=29829 -> irq stays 1.
- Write 0x80 at phase=0:
  - Exactly 4 cpu_en later, q+h strobe and cnt=0.
  - Repeat at phase=1 -> 3 cpu_en.
  - 5-step frame then gives q+h at 37281 and no irq.
- Write 0x40 while irq=1 -> irq=0 same+1 clk. No irq set at 29828..29830 thereafter.
- Second write during pending delay (0x80 then 0x00 one cpu_en later) -> single counter reset timed from the second write, no immediate q+h.
- Assert reset at cnt=14913 with a write pending -> all outputs 0, cnt restarts at 0, no strobe from the pending write.
